uart_debug_top: RTL and testbench

//  Debug/loader top: a UART loads a program into instruction memory and selects continuous or

---
 rtl/debug_pkg.sv | 28 ++
 rtl/uart_core.sv | 130 +++++++++++++
 rtl/uart_debug_top.sv | 133 +++++++++++++
 tb/tb_uart_debug_top.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the UART debug/loader block.
// Optional feature macro: DUMP_CYCLES_EN (appends a 32-bit executed-fetch count to each dump).
package debug_pkg;

    typedef enum logic [2:0] {
        ST_LOAD, ST_MODE, ST_WAIT_GO, ST_RUN, ST_STEP_WAIT, ST_STEP_EXEC, ST_DUMP, ST_FINISHED
    } dbg_state_e;

    typedef enum logic [1:0] {UR_IDLE, UR_START, UR_DATA, UR_STOP} uart_st_e;

    localparam logic MODE_CONT = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam int DUMP_BYTES_BASE = 5;
    localparam int DUMP_BYTES_CYC  = 9;
`ifdef DUMP_CYCLES_EN
    localparam int DUMP_BYTES = DUMP_BYTES_CYC;
`else
    localparam int DUMP_BYTES = DUMP_BYTES_BASE;
`endif

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_core.sv
// 8N1 UART receiver and transmitter sharing one bit period; LSB first, idle high.
module uart_core
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10432
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_start_i,
    output logic       tx_busy_o,
    output logic       tx_done_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_q, rx_sync_q, rx_prev_q, rx_valid_q;
    uart_st_e      rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q, rx_data_q;

    // Falling-edge detect on the synchronised line; a line stuck low never restarts a frame.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= UR_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            case (rx_st_q)
                UR_IDLE: if (rx_prev_q && !rx_sync_q) begin
                    rx_st_q  <= UR_START;
                    rx_cnt_q <= '0;
                end
                UR_START: if (rx_cnt_q == HALF) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= rx_sync_q ? UR_IDLE : UR_DATA;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                UR_DATA: if (rx_cnt_q == FULL) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_sync_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_st_q <= UR_STOP;
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
                default: if (rx_cnt_q == FULL) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= UR_IDLE;
                    if (rx_sync_q) begin
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                    end
                end else rx_cnt_q <= rx_cnt_q + 1'b1;
            endcase
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

    logic          tx_q, tx_done_q;
    uart_st_e      tx_st_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
            tx_st_q   <= UR_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_st_q)
                UR_IDLE: if (tx_start_i) begin
                    tx_sh_q  <= tx_data_i;
                    tx_q     <= 1'b0;
                    tx_cnt_q <= '0;
                    tx_st_q  <= UR_START;
                end
                UR_START: if (tx_cnt_q == FULL) begin
                    tx_cnt_q <= '0;
                    tx_q     <= tx_sh_q[0];
                    tx_sh_q  <= tx_sh_q >> 1;
                    tx_bit_q <= '0;
                    tx_st_q  <= UR_DATA;
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                UR_DATA: if (tx_cnt_q == FULL) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_q    <= 1'b1;
                        tx_st_q <= UR_STOP;
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_bit_q <= tx_bit_q + 1'b1;
                    end
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
                default: if (tx_cnt_q == FULL) begin
                    tx_cnt_q  <= '0;
                    tx_done_q <= 1'b1;
                    tx_st_q   <= UR_IDLE;
                end else tx_cnt_q <= tx_cnt_q + 1'b1;
            endcase
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = (tx_st_q != UR_IDLE);
    assign tx_done_o = tx_done_q;

endmodule

// File: rtl/uart_debug_top.sv
// UART program loader, minimal fetch sequencer and PC/status dumper.
// Define DUMP_CYCLES_EN to append the executed-fetch count to every dump.
module uart_debug_top
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10432,
    parameter int IMEM_DEPTH   = 64
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_rx_done,
    output logic       o_tx_done,
    output logic       o_done,
    output logic [7:0] o_rx_data,
    output logic       o_halt
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [7:0]  rx_data, tx_data_q, dump_byte;
    logic        rx_valid, tx_busy, tx_done, tx_start_q;
    dbg_state_e  state_q;
    logic [31:0] pc_q, word_q, word_full, fetch_word;
    logic [AW:0] wcnt_q;
    logic [1:0]  byte_idx_q;
    logic [3:0]  dump_idx_q;
    logic        mode_q, halt_q, done_q, imem_we, exec_en, fetch_halt;
    logic [31:0] imem_q [IMEM_DEPTH];

    uart_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk_i      (i_clk),
        .reset_i    (i_reset),
        .rx_i       (i_rx),
        .tx_o       (o_tx),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .tx_data_i  (tx_data_q),
        .tx_start_i (tx_start_q),
        .tx_busy_o  (tx_busy),
        .tx_done_o  (tx_done)
    );

    assign word_full  = {rx_data, word_q[31:8]};
    assign imem_we    = (state_q == ST_LOAD) && rx_valid && (byte_idx_q == 2'd3)
                        && (wcnt_q < (AW+1)'(IMEM_DEPTH));
    assign fetch_word = imem_q[pc_q[AW+1:2]];
    assign fetch_halt = (pc_q[31:2] >= 30'(IMEM_DEPTH)) || (fetch_word == HALT_WORD);
    assign exec_en    = ((state_q == ST_RUN) && i_valid) || (state_q == ST_STEP_EXEC);

    always_ff @(posedge i_clk) begin
        if (imem_we) imem_q[wcnt_q[AW-1:0]] <= word_full;
    end

`ifdef DUMP_CYCLES_EN
    logic [31:0] cyc_q;
    always_ff @(posedge i_clk) begin
        if (i_reset)      cyc_q <= '0;
        else if (exec_en) cyc_q <= cyc_q + 1'b1;
    end
`endif

    always_comb begin
        dump_byte = 8'h00;
        if (dump_idx_q < 4'd4)       dump_byte = word_byte(pc_q, dump_idx_q[1:0]);
        else if (dump_idx_q == 4'd4) dump_byte = {7'b0, halt_q};
`ifdef DUMP_CYCLES_EN
        else                         dump_byte = word_byte(cyc_q, 2'(dump_idx_q - 4'd5));
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_LOAD;
            pc_q       <= '0;
            word_q     <= '0;
            wcnt_q     <= '0;
            byte_idx_q <= '0;
            dump_idx_q <= '0;
            mode_q     <= MODE_CONT;
            halt_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            if (exec_en) begin
                if (fetch_halt) halt_q <= 1'b1;
                else            pc_q   <= pc_q + 32'd4;
            end
            case (state_q)
                ST_LOAD: if (rx_valid) begin
                    word_q     <= word_full;
                    byte_idx_q <= byte_idx_q + 1'b1;
                    if (byte_idx_q == 2'd3) begin
                        if (wcnt_q < (AW+1)'(IMEM_DEPTH)) wcnt_q <= wcnt_q + 1'b1;
                        if (word_full == HALT_WORD) state_q <= ST_MODE;
                    end
                end
                ST_MODE: if (rx_valid) begin
                    mode_q  <= rx_data[0];
                    state_q <= (rx_data[0] == MODE_STEP) ? ST_STEP_WAIT : ST_WAIT_GO;
                end
                ST_WAIT_GO:   if (rx_valid) state_q <= ST_RUN;
                ST_RUN:       if (i_valid && fetch_halt) state_q <= ST_DUMP;
                ST_STEP_WAIT: if (rx_valid && rx_data[0] && i_valid) state_q <= ST_STEP_EXEC;
                ST_STEP_EXEC: state_q <= ST_DUMP;
                // tx_start_q is still visible the cycle before busy rises, so it gates re-issue.
                ST_DUMP: if (dump_idx_q < 4'(DUMP_BYTES)) begin
                    if (!tx_busy && !tx_start_q) begin
                        tx_data_q  <= dump_byte;
                        tx_start_q <= 1'b1;
                        dump_idx_q <= dump_idx_q + 1'b1;
                    end
                end else if (tx_done) begin
                    done_q     <= 1'b1;
                    dump_idx_q <= '0;
                    state_q    <= (mode_q == MODE_CONT || halt_q) ? ST_FINISHED : ST_STEP_WAIT;
                end
                default: ;
            endcase
        end
    end

    assign o_rx_done = rx_valid;
    assign o_rx_data = rx_data;
    assign o_tx_done = tx_done;
    assign o_done    = done_q;
    assign o_halt    = halt_q;

endmodule

// File: tb/tb_uart_debug_top.sv
// Directed bench for uart_debug_top: loader, continuous and step runs, framing errors.
module tb_uart_debug_top;
    localparam int CPB = 16;
`ifdef DUMP_CYCLES_EN
    localparam int DB = 9;
`else
    localparam int DB = 5;
`endif

    logic       clk = 1'b0;
    logic       i_reset = 1'b1, i_valid = 1'b0, i_rx = 1'b1;
    logic       o_tx, o_rx_done, o_tx_done, o_done, o_halt;
    logic [7:0] o_rx_data;

    int n_vec = 0, n_err = 0;
    int done_cnt = 0, rxd_cnt = 0;
    logic [7:0] txq[$];

    always #5 clk = ~clk;

    uart_debug_top #(.CLKS_PER_BIT(CPB), .IMEM_DEPTH(64)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_rx(i_rx),
        .o_tx(o_tx), .o_rx_done(o_rx_done), .o_tx_done(o_tx_done), .o_done(o_done),
        .o_rx_data(o_rx_data), .o_halt(o_halt)
    );

    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (o_rx_done) rxd_cnt++;
    end

    // Serial decoder for o_tx, sampling mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (!i_reset && o_tx === 1'b0) begin
                logic [7:0] b;
                b = 8'h00;
                repeat (CPB/2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = o_tx;
                end
                repeat (CPB) @(negedge clk);
                txq.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        i_rx = stop;
        repeat (CPB) @(negedge clk);
        i_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_rx = 1'b1;
        repeat (10) @(negedge clk);
        i_reset = 1'b0;
        txq.delete();
    endtask

    task automatic check_dump(input string tag, input logic [31:0] pc, input logic [7:0] st,
                              input logic [31:0] cyc);
        logic [7:0] exp[9];
        logic [7:0] b;
        int budget;
        for (int k = 0; k < 4; k++) exp[k] = pc[8*k +: 8];
        exp[4] = st;
        for (int k = 0; k < 4; k++) exp[5+k] = cyc[8*k +: 8];
        budget = 5000;
        while (txq.size() < DB && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk({tag, "_nbytes"}, txq.size(), DB);
        for (int k = 0; k < DB; k++) begin
            b = 8'hxx;
            if (txq.size() > 0) b = txq.pop_front();
            chk($sformatf("%s_b%0d", tag, k), {24'h0, b}, {24'h0, exp[k]});
        end
        repeat (3*CPB) @(negedge clk);
    endtask

    initial begin
        int d0, r0;
        // Reset
        repeat (10) @(negedge clk);
        chk("rst_tx", o_tx, 1);
        chk("rst_halt", o_halt, 0);
        chk("rst_done", o_done, 0);
        chk("rst_rxdone", o_rx_done, 0);
        chk("rst_rxdata", o_rx_data, 0);
        r0 = rxd_cnt;
        i_reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_no_rxdone", rxd_cnt - r0, 0);

        // Continuous run, bad-stop byte mid-load, i_valid held low after go
        do_reset();
        d0 = done_cnt;
        send_word(32'h0000_0001);
        chk("rxdata_last", o_rx_data, 8'h00);
        r0 = rxd_cnt;
        send_byte(8'h55, 1'b0);
        chk("badstop_no_pulse", rxd_cnt - r0, 0);
        chk("badstop_data_held", o_rx_data, 8'h00);
        send_word(32'h0000_0002);
        send_word(32'hFFFF_FFFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (300) @(negedge clk);
        chk("frozen_no_tx", txq.size(), 0);
        chk("frozen_no_done", done_cnt - d0, 0);
        chk("frozen_no_halt", o_halt, 0);
        i_valid = 1'b1;
        check_dump("cont", 32'd8, 8'h01, 32'd3);
        chk("cont_done", done_cnt - d0, 1);
        chk("cont_halt", o_halt, 1);

        // Step mode
        do_reset();
        d0 = done_cnt;
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send_word(32'hFFFF_FFFF);
        send_byte(8'h01, 1'b1);
        i_valid = 1'b1;
        send_byte(8'h00, 1'b1);
        repeat (300) @(negedge clk);
        chk("step0_ignored", txq.size(), 0);
        send_byte(8'h01, 1'b1);
        check_dump("step1", 32'd4, 8'h00, 32'd1);
        chk("step1_done", done_cnt - d0, 1);
        chk("step1_halt", o_halt, 0);
        send_byte(8'h01, 1'b1);
        check_dump("step2", 32'd8, 8'h00, 32'd2);
        chk("step2_done", done_cnt - d0, 2);
        send_byte(8'h01, 1'b1);
        check_dump("step3", 32'd8, 8'h01, 32'd3);
        chk("step3_done", done_cnt - d0, 3);
        chk("step3_halt", o_halt, 1);

        // FINISHED: bytes still update rx outputs, FSM stays put
        r0 = rxd_cnt;
        send_byte(8'hA5, 1'b1);
        repeat (300) @(negedge clk);
        chk("fin_no_tx", txq.size(), 0);
        chk("fin_done", done_cnt - d0, 3);
        chk("fin_rxdone", rxd_cnt - r0, 1);
        chk("fin_rxdata", o_rx_data, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
